// File: rtl/icache_req_arbiter_pkg.sv
// Shared types for the ICache request arbiter: address/data widths, the
// valid/ready handshake bundle and the owner tag tracked per outstanding request.
package icache_req_arbiter_pkg;

    localparam int VLEN            = 32;
    localparam int ILEN            = 32;
    localparam int INSTR_PER_FETCH = 2;

    typedef logic [VLEN-1:0]                       vaddr_t;
    typedef logic [INSTR_PER_FETCH-1:0][ILEN-1:0]  fetch_data_t;

    typedef struct packed {
        logic valid;
        logic ready;
    } handshake_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_PF    = 1'b1
    } icache_owner_e;

    typedef struct packed {
        icache_owner_e owner;
        logic          squashed;
    } icache_tag_t;

endpackage

// File: rtl/icache_owner_fifo.sv
// In-order FIFO of owner tags for accepted ICache requests; squash_all marks
// every stored entry as squashed so its late response is drained and dropped.
module icache_owner_fifo
    import icache_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  icache_tag_t push_tag,
    input  logic        pop,
    input  logic        squash_all,
    output icache_tag_t head_tag,
    output logic        empty,
    output logic        full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    icache_tag_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_tag = mem[rd_ptr];

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (!do_push && do_pop)
                count <= count - CNT_W'(1);
        end
    end

    // NOTE: tag storage is deliberately not reset; an entry is only read after
    // it has been written, and count/pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (squash_all) begin
            for (int i = 0; i < DEPTH; i++) mem[i].squashed <= 1'b1;
        end
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/icache_req_arbiter.sv
// Shares the ICache port between demand fetch (fixed priority) and the
// next-line prefetcher, with a starvation guard and in-order response routing.
module icache_req_arbiter
    import icache_req_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        fetch_req_valid_i,
    output logic        fetch_req_ready_o,
    input  vaddr_t      fetch_req_addr_i,
    input  logic        pf_req_valid_i,
    output logic        pf_req_ready_o,
    input  vaddr_t      pf_req_addr_i,
    output handshake_t  ic_req_o,
    input  handshake_t  ic_req_i,
    output vaddr_t      ic_req_addr_o,
    input  handshake_t  ic_rsp_i,
    output handshake_t  ic_rsp_o,
    input  fetch_data_t ic_rsp_data_i,
    output logic        fetch_rsp_valid_o,
    input  logic        fetch_rsp_ready_i,
    output fetch_data_t fetch_rsp_data_o,
    output logic        pf_rsp_valid_o,
    output logic        busy_o
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic                can_issue;
    logic                sel_pf;
    logic                sel_valid;
    logic                accept;
    logic                fetch_accept;
    logic                pf_accept;
    logic                fifo_pop;
    logic                fifo_empty;
    logic                fifo_full;
    icache_tag_t         head_tag;
    icache_tag_t         push_tag;
    logic [STARVE_W-1:0] starve_cnt;
    logic                unused_hs_bits;

    assign unused_hs_bits = ic_req_i.valid ^ ic_rsp_i.ready;

    // Request side: fetch wins unless the prefetcher has waited STARVE_LIMIT grants.
    assign can_issue = !rst && !flush_i && !fifo_full;
    assign sel_pf    = pf_req_valid_i &&
                       (!fetch_req_valid_i || starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign sel_valid = sel_pf ? pf_req_valid_i : fetch_req_valid_i;

    assign ic_req_o.valid    = can_issue && sel_valid;
    assign ic_req_o.ready    = 1'b0;
    assign ic_req_addr_o     = sel_pf ? pf_req_addr_i : fetch_req_addr_i;
    assign fetch_req_ready_o = !sel_pf && can_issue && ic_req_i.ready;
    assign pf_req_ready_o    = sel_pf && can_issue && ic_req_i.ready;

    assign accept       = ic_req_o.valid && ic_req_i.ready;
    assign fetch_accept = accept && !sel_pf;
    assign pf_accept    = accept && sel_pf;
    assign push_tag     = '{owner: sel_pf ? OWN_PF : OWN_FETCH, squashed: 1'b0};

    always_ff @(posedge clk) begin
        if (rst || flush_i || pf_accept || !pf_req_valid_i)
            starve_cnt <= '0;
        else if (fetch_accept && starve_cnt != STARVE_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + STARVE_W'(1);
    end

    icache_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_tag   (push_tag),
        .pop        (fifo_pop),
        .squash_all (flush_i),
        .head_tag   (head_tag),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // Response side: zero-latency routing by the owner at the FIFO head.
    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        ic_rsp_o          = '0;
        fetch_rsp_valid_o = 1'b0;
        pf_rsp_valid_o    = 1'b0;
        fifo_pop          = 1'b0;
        if (!fifo_empty) begin
            if (flush_i || head_tag.squashed) begin
                ic_rsp_o.ready = 1'b1;
                fifo_pop       = ic_rsp_i.valid;
            end else if (head_tag.owner == OWN_FETCH) begin
                fetch_rsp_valid_o = ic_rsp_i.valid;
                ic_rsp_o.ready    = fetch_rsp_ready_i;
                fifo_pop          = ic_rsp_i.valid && fetch_rsp_ready_i;
            end else begin
                pf_rsp_valid_o = ic_rsp_i.valid;
                ic_rsp_o.ready = 1'b1;
                fifo_pop       = ic_rsp_i.valid;
            end
        end
    end

    assign fetch_rsp_data_o = ic_rsp_data_i;
    assign busy_o           = !fifo_empty;

    // A response with nothing outstanding means the ICache and this block disagree.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(ic_rsp_i.valid && fifo_empty));

endmodule

// File: tb/tb_icache_req_arbiter.sv
// Directed bench for icache_req_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for addresses/data, starvation order and reset.
module tb_icache_req_arbiter;
    import icache_req_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        fetch_req_valid_i;
    logic        fetch_req_ready_o;
    vaddr_t      fetch_req_addr_i;
    logic        pf_req_valid_i;
    logic        pf_req_ready_o;
    vaddr_t      pf_req_addr_i;
    handshake_t  ic_req_o;
    handshake_t  ic_req_i;
    vaddr_t      ic_req_addr_o;
    handshake_t  ic_rsp_i;
    handshake_t  ic_rsp_o;
    fetch_data_t ic_rsp_data_i;
    logic        fetch_rsp_valid_o;
    logic        fetch_rsp_ready_i;
    fetch_data_t fetch_rsp_data_o;
    logic        pf_rsp_valid_o;
    logic        busy_o;

    icache_req_arbiter #(
        .MAX_OUTSTANDING (2),
        .STARVE_LIMIT    (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .fetch_req_valid_i (fetch_req_valid_i),
        .fetch_req_ready_o (fetch_req_ready_o),
        .fetch_req_addr_i  (fetch_req_addr_i),
        .pf_req_valid_i    (pf_req_valid_i),
        .pf_req_ready_o    (pf_req_ready_o),
        .pf_req_addr_i     (pf_req_addr_i),
        .ic_req_o          (ic_req_o),
        .ic_req_i          (ic_req_i),
        .ic_req_addr_o     (ic_req_addr_o),
        .ic_rsp_i          (ic_rsp_i),
        .ic_rsp_o          (ic_rsp_o),
        .ic_rsp_data_i     (ic_rsp_data_i),
        .fetch_rsp_valid_o (fetch_rsp_valid_o),
        .fetch_rsp_ready_i (fetch_rsp_ready_i),
        .fetch_rsp_data_o  (fetch_rsp_data_o),
        .pf_rsp_valid_o    (pf_rsp_valid_o),
        .busy_o            (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Inputs {flush, f_valid, p_valid, ic_req_ready, ic_rsp_valid, f_rsp_ready};
    // expected {ic_req_valid, f_ready, p_ready, f_rsp_valid, p_rsp_valid, ic_rsp_ready, busy}.
    typedef struct {
        logic [5:0] stim;
        logic [6:0] exp;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] s);
        {flush_i, fetch_req_valid_i, pf_req_valid_i, ic_req_i.ready,
         ic_rsp_i.valid, fetch_rsp_ready_i} = s;
    endtask

    function automatic logic [6:0] outs();
        return {ic_req_o.valid, fetch_req_ready_o, pf_req_ready_o,
                fetch_rsp_valid_o, pf_rsp_valid_o, ic_rsp_o.ready, busy_o};
    endfunction

    initial begin
        int outst;
        int got;
        logic grants [10];
        logic acc;
        logic popped;

        vecs[0]  = '{6'b000000, 7'b0000000};  // idle
        vecs[1]  = '{6'b010100, 7'b1100000};  // F issue
        vecs[2]  = '{6'b000011, 7'b0001011};  // F rsp next cycle
        vecs[3]  = '{6'b000000, 7'b0000000};  // busy drops
        vecs[4]  = '{6'b001100, 7'b1010000};  // P alone issues
        vecs[5]  = '{6'b000010, 7'b0000111};  // P rsp, always ready
        vecs[6]  = '{6'b011100, 7'b1100000};  // F beats P
        vecs[7]  = '{6'b011100, 7'b1100001};  // second F fills FIFO
        vecs[8]  = '{6'b011100, 7'b0000001};  // full: no issue
        vecs[9]  = '{6'b011110, 7'b0001001};  // F rsp backpressured
        vecs[10] = '{6'b011111, 7'b0001011};  // pop while full: still no issue
        vecs[11] = '{6'b011100, 7'b1100001};  // freed entry reused
        vecs[12] = '{6'b111111, 7'b0000011};  // flush with head rsp: dropped
        vecs[13] = '{6'b011100, 7'b1100011};  // issue after flush, squashed head
        vecs[14] = '{6'b000010, 7'b0000011};  // squashed rsp drained silently
        vecs[15] = '{6'b000011, 7'b0001011};  // post-flush F rsp delivered
        vecs[16] = '{6'b000000, 7'b0000000};
        vecs[17] = '{6'b010100, 7'b1100000};
        vecs[18] = '{6'b010100, 7'b1100001};
        vecs[19] = '{6'b100000, 7'b0000011};  // flush, two in flight
        vecs[20] = '{6'b100000, 7'b0000011};  // back-to-back flush
        vecs[21] = '{6'b000010, 7'b0000011};
        vecs[22] = '{6'b000010, 7'b0000011};
        vecs[23] = '{6'b000000, 7'b0000000};

        rst              = 1'b1;
        drive(6'b000000);
        fetch_req_addr_i = 32'h8000_0000;
        pf_req_addr_i    = 32'h8000_0040;
        ic_req_i.valid   = 1'b0;
        ic_rsp_i.ready   = 1'b0;
        ic_rsp_data_i    = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'(outs()), 64'h0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].stim);
            #1;
            check($sformatf("row%0d", i), 64'(outs()), 64'(vecs[i].exp));
        end

        // Address mux and data pass-through.
        @(negedge clk);
        drive(6'b010100);
        #1;
        check("f_addr", 64'(ic_req_addr_o), 64'h8000_0000);
        @(negedge clk);
        drive(6'b000011);
        ic_rsp_data_i = 64'hDEAD_BEEF_0000_0013;
        #1;
        check("f_rsp_valid", 64'(fetch_rsp_valid_o), 64'h1);
        check("f_rsp_data", 64'(fetch_rsp_data_o), 64'hDEAD_BEEF_0000_0013);
        @(negedge clk);
        drive(6'b001100);
        #1;
        check("busy_after_f", 64'(busy_o), 64'h0);
        check("p_addr", 64'(ic_req_addr_o), 64'h8000_0040);
        @(negedge clk);
        drive(6'b000010);
        #1;
        check("p_rsp_valid", 64'(pf_rsp_valid_o), 64'h1);

        // Continuous F and P with a one-cycle-latency ICache.
        outst = 0;
        got   = 0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            @(negedge clk);
            drive({1'b0, 1'b1, 1'b1, 1'b1, (outst > 0), 1'b1});
            #1;
            acc    = ic_req_o.valid && ic_req_i.ready;
            popped = ic_rsp_i.valid && ic_rsp_o.ready;
            if (acc) begin
                grants[got] = pf_req_ready_o;
                got++;
            end
            outst = outst + int'(acc) - int'(popped);
        end
        check("starve_grant_count", 64'(got), 64'd10);
        for (int i = 0; i < got; i++)
            check($sformatf("starve_grant%0d", i), 64'(grants[i]), 64'((i % 5) == 4));
        for (int cyc = 0; cyc < 10 && outst > 0; cyc++) begin
            @(negedge clk);
            drive({5'b00001, 1'b1});
            #1;
            if (ic_rsp_o.ready) outst--;
        end
        @(negedge clk);
        drive(6'b000000);
        #1;
        check("busy_after_drain", 64'(busy_o), 64'h0);

        // Reset mid-operation clears the FIFO.
        @(negedge clk);
        drive(6'b010100);
        @(negedge clk);
        drive(6'b010100);
        #1;
        check("busy_before_rst", 64'(busy_o), 64'h1);
        @(negedge clk);
        drive(6'b000000);
        rst = 1'b1;
        @(negedge clk);
        check("busy_in_rst", 64'(busy_o), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        drive(6'b010100);
        #1;
        check("issue_after_rst", 64'(outs()), 64'b1100000);
        @(negedge clk);
        drive(6'b000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
